enemy_fire_scheduler: RTL

Schedules the single enemy-bullet resource among the five enemy entities. It waits a pseudo-random number of game ticks, then picks the next live shooter in round-robin order. It issues a spawn request with position to the enemy-bullet datapath inside `entities` and blocks until that bullet has left play. It sits between the enemy formation state (`inimigo_x`, `inimigo_y`, `inimigo_vivo_array`) and the bullet datapath's spawn port.

---
 rtl/enemy_fire_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: arbitrates the single enemy bullet among the
// formation, with a random cooldown and round-robin shooter choice.
module enemy_fire_scheduler #(
    parameter int          N_ENEMY       = 5,
    parameter int          COOLDOWN_MIN  = 8,
    parameter logic [7:0]  COOLDOWN_MASK = 8'h1F,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [9:0]  X_OFFSET      = 10'd12,
    parameter logic [9:0]  Y_OFFSET      = 10'd16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick,
    input  logic        pausa,
    input  logic [0:4]  inimigo_vivo_array,
    input  logic [49:0] inimigo_x,
    input  logic [49:0] inimigo_y,
    input  logic        bullet_active,
    output logic        fire_req,
    input  logic        fire_ack,
    output logic [9:0]  fire_x,
    output logic [9:0]  fire_y,
    output logic [2:0]  shooter_id,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_COOL = 3'd1,
        S_SEL  = 3'd2,
        S_REQ  = 3'd3,
        S_FLT  = 3'd4
    } state_t;

    localparam logic [3:0]  L_N    = 4'(N_ENEMY);
    localparam logic [2:0]  L_LAST = 3'(N_ENEMY - 1);
    localparam logic [15:0] L_TAPS = 16'hB400;
    localparam logic [8:0]  L_MIN  = 9'(COOLDOWN_MIN);

    state_t      r_state;
    logic [8:0]  r_cnt;
    logic [2:0]  r_rr;
    logic [15:0] r_lfsr;
    logic        r_req;
    logic [9:0]  r_fx;
    logic [9:0]  r_fy;
    logic [2:0]  r_sid;
    logic        r_first;

    state_t      w_state_nxt;
    logic [8:0]  w_cnt_nxt;
    logic [2:0]  w_rr_nxt;
    logic [15:0] w_lfsr_nxt;
    logic        w_req_nxt;
    logic [9:0]  w_fx_nxt;
    logic [9:0]  w_fy_nxt;
    logic [2:0]  w_sid_nxt;
    logic        w_first_nxt;

    logic        w_found;
    logic [2:0]  w_pick;
    logic [3:0]  w_cand;
    logic [9:0]  w_xi;
    logic [9:0]  w_yi;
    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic [9:0]  w_fx_sat;
    logic [9:0]  w_fy_sat;
    logic [8:0]  w_load;
    logic        w_any;

    // Galois LFSR step; the random part of each cooldown comes from it
    always_comb begin
        w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? L_TAPS : 16'h0000);
    end

    assign w_load = L_MIN + {1'b0, r_lfsr[7:0] & COOLDOWN_MASK};
    assign w_any  = |inimigo_vivo_array;

    // Round-robin scan: first live enemy at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_cand  = 4'd0;
        for (int k = 0; k < N_ENEMY; k++) begin
            w_cand = {1'b0, r_rr} + 4'(k);
            if (w_cand >= L_N) begin
                w_cand = w_cand - L_N;
            end
            if (!w_found && inimigo_vivo_array[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[2:0];
            end
        end
    end

    // Fetch the chosen enemy's position from the packed buses
    always_comb begin
        w_xi = 10'd0;
        w_yi = 10'd0;
        for (int k = 0; k < N_ENEMY; k++) begin
            if (w_pick == 3'(k)) begin
                w_xi = inimigo_x[k*10 +: 10];
                w_yi = inimigo_y[k*10 +: 10];
            end
        end
    end

    assign w_sx     = {1'b0, w_xi} + {1'b0, X_OFFSET};
    assign w_sy     = {1'b0, w_yi} + {1'b0, Y_OFFSET};
    assign w_fx_sat = w_sx[10] ? 10'h3FF : w_sx[9:0];
    assign w_fy_sat = w_sy[10] ? 10'h3FF : w_sy[9:0];

    // Next-state and next-output decision for the firing FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_req_nxt   = r_req;
        w_fx_nxt    = r_fx;
        w_fy_nxt    = r_fy;
        w_sid_nxt   = r_sid;
        w_first_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any && !pausa) begin
                    w_state_nxt = S_COOL;
                    w_cnt_nxt   = w_load;
                end
            end
            S_COOL: begin
                if (r_cnt == 9'd0) begin
                    w_state_nxt = S_SEL;
                end else if (tick && !pausa) begin
                    w_cnt_nxt = r_cnt - 9'd1;
                end
            end
            S_SEL: begin
                if (!w_found) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_sid_nxt = w_pick;
                    w_fx_nxt  = w_fx_sat;
                    w_fy_nxt  = w_fy_sat;
                    w_rr_nxt  = (w_pick == L_LAST) ? 3'd0 : w_pick + 3'd1;
                    if (!pausa) begin
                        w_state_nxt = S_REQ;
                        w_req_nxt   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (fire_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_FLT;
                    w_first_nxt = 1'b1;
                end else if (!inimigo_vivo_array[r_sid]) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_SEL;
                end
            end
            S_FLT: begin
                if (!r_first && !bullet_active) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 9'd0;
            r_rr    <= 3'd0;
            r_lfsr  <= LFSR_SEED;
            r_req   <= 1'b0;
            r_fx    <= 10'd0;
            r_fy    <= 10'd0;
            r_sid   <= 3'd0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_req   <= w_req_nxt;
            r_fx    <= w_fx_nxt;
            r_fy    <= w_fy_nxt;
            r_sid   <= w_sid_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign fire_req   = r_req;
    assign fire_x     = r_fx;
    assign fire_y     = r_fy;
    assign shooter_id = r_sid;
    assign state      = r_state;

endmodule
